// File: rtl/lpmul_pipe.sv
// Multi-lane pipelined low-precision multiplier with valid/ready handshake at both ends.
// Products are formed on entry; optional clamping is applied at the output of the last stage.
module lpmul_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH-1:0]     op_a,
    input  logic [LANES*WIDTH-1:0]     op_b,
    input  logic                       sign,
    input  logic                       sat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*2*WIDTH-1:0]   res,
    output logic [LANES-1:0]           sat_flag
);

    localparam int PW = 2 * WIDTH;

    logic [STAGES-1:0]     vld_q, vld_d, adv;
    logic [STAGES-1:0]     sgn_q, sgn_d, sat_q, sat_d;
    logic [LANES*PW-1:0]   prod_q [STAGES];
    logic [LANES*PW-1:0]   prod_d [STAGES];
    logic [LANES*PW-1:0]   prod_in;

    // Low PW bits of the extended product are exact for both signed and unsigned operands.
    function automatic logic [PW-1:0] mul_lane(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        logic signed [PW-1:0] full;
        ax   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bx   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        full = ax * bx;
        return full;
    endfunction

    // Returns {clamped_flag, value}; value is already extended to PW bits.
    function automatic logic [PW:0] clamp_lane(input logic [PW-1:0] p,
                                               input logic          sgn,
                                               input logic          sat_en);
        logic [PW-1:0] r;
        logic          f;
        r = p;
        f = 1'b0;
        if (sat_en) begin
            if (sgn) begin
                if (p[PW-1] && !(&p[PW-1:WIDTH-1])) begin
                    r = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
                    f = 1'b1;
                end else if (!p[PW-1] && (|p[PW-1:WIDTH-1])) begin
                    r = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
                    f = 1'b1;
                end
            end else if (|p[PW-1:WIDTH]) begin
                r = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                f = 1'b1;
            end
        end
        return {f, r};
    endfunction

    always_comb begin
        prod_in = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_in[i*PW +: PW] = mul_lane(op_a[i*WIDTH +: WIDTH], op_b[i*WIDTH +: WIDTH], sign);
        end
    end

    // A stage advances if it or any later stage is empty, or the tail is draining.
    always_comb begin
        logic adv_any;
        adv     = '0;
        adv_any = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            adv_any = out_ready;
            for (int j = k; j < STAGES; j++) begin
                adv_any = adv_any | !vld_q[j];
            end
            adv[k] = adv_any;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        sgn_d  = sgn_q;
        sat_d  = sat_q;
        prod_d = prod_q;
        if (adv[0]) begin
            vld_d[0]  = in_valid;
            sgn_d[0]  = sign;
            sat_d[0]  = sat;
            prod_d[0] = prod_in;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                vld_d[k]  = vld_q[k-1];
                sgn_d[k]  = sgn_q[k-1];
                sat_d[k]  = sat_q[k-1];
                prod_d[k] = prod_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        sgn_q  <= sgn_d;
        sat_q  <= sat_d;
        prod_q <= prod_d;
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];

    // Output stage: clamp, and hold the bus at zero whenever nothing valid is presented.
    always_comb begin
        logic [PW:0] c;
        c        = '0;
        res      = '0;
        sat_flag = '0;
        for (int i = 0; i < LANES; i++) begin
            c = clamp_lane(prod_q[STAGES-1][i*PW +: PW], sgn_q[STAGES-1], sat_q[STAGES-1]);
            if (out_valid) begin
                res[i*PW +: PW] = c[PW-1:0];
                sat_flag[i]     = c[PW];
            end
        end
    end

endmodule

// File: tb/tb_lpmul_pipe.sv
// Bench for lpmul_pipe: directed vectors, backpressure, throughput, random traffic and mid-flight reset,
// checked against an integer-arithmetic model and an in-order queue of outstanding transactions.
module tb_lpmul_pipe;

    localparam int W = 8;
    localparam int L = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] op_a = '0;
    logic [L*W-1:0] op_b = '0;
    logic           sign = 1'b0;
    logic           sat = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [L*2*W-1:0] res;
    logic [L-1:0]   sat_flag;

    lpmul_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .sign     (sign),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic [3:0]  f;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    int          pops = 0;
    bit          exact_lat = 1'b0;
    logic [63:0] last_res = '0;
    logic [3:0]  last_flag = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sg, input logic st,
                                  output logic [63:0] r, output logic [3:0] f);
        int ai, bi, p;
        r = '0;
        f = '0;
        for (int i = 0; i < L; i++) begin
            ai = int'(a[i*W +: W]);
            bi = int'(b[i*W +: W]);
            if (sg && ai > 127) ai -= 256;
            if (sg && bi > 127) bi -= 256;
            p = ai * bi;
            if (st) begin
                if (sg) begin
                    if (p > 127) begin p = 127; f[i] = 1'b1; end
                    else if (p < -128) begin p = -128; f[i] = 1'b1; end
                end else if (p > 255) begin
                    p = 255; f[i] = 1'b1;
                end
            end
            r[i*16 +: 16] = p[15:0];
        end
    endfunction

    // One clock: drive at the falling edge, inspect settled outputs, then cross the next rising edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic st, input logic ordy, output bit acc);
        exp_t        e;
        logic [63:0] r;
        logic [3:0]  f;
        in_valid  = v;
        op_a      = a;
        op_b      = b;
        sign      = sg;
        sat       = st;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, (q.size() == S && !ordy) ? 0 : 1);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                chk("res", res, q[0].r);
                chk("sat_flag", sat_flag, q[0].f);
                if (ordy) begin
                    if (exact_lat) chk("latency", edge_cnt - q[0].acc, S);
                    last_res  = res;
                    last_flag = sat_flag;
                    pops++;
                    void'(q.pop_front());
                end
            end
        end
        acc = v && in_ready;
        if (acc) begin
            model(a, b, sg, st, r, f);
            e.r   = r;
            e.f   = f;
            e.acc = edge_cnt;
            q.push_back(e);
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    initial begin
        bit   acc;
        int   idx;
        int   p0;
        logic [31:0] ta [6];
        logic [31:0] tb [6];

        // Reset and idle
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_res", res, 0);
        chk("reset_sat_flag", sat_flag, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed signed / unsigned vectors with exact latency
        exact_lat = 1'b1;
        cycle(1'b1, 32'h00_80_80_7F, 32'hFB_7F_80_7F, 1'b1, 1'b0, 1'b1, acc);
        chk("dir_s_acc", acc, 1);
        idle(3, 1'b1);
        chk("signed_exact", last_res, 64'h0000_C080_4000_3F01);
        chk("signed_exact_flag", last_flag, 4'b0000);

        cycle(1'b1, 32'h00_80_80_7F, 32'hFB_7F_80_7F, 1'b1, 1'b1, 1'b1, acc);
        idle(3, 1'b1);
        chk("signed_sat", last_res, 64'h0000_FF80_007F_007F);
        chk("signed_sat_flag", last_flag, 4'b0111);

        cycle(1'b1, 32'hC8_01_10_FF, 32'h02_00_0F_FF, 1'b0, 1'b0, 1'b1, acc);
        idle(3, 1'b1);
        chk("unsigned_exact", last_res, 64'h0190_0000_00F0_FE01);
        chk("unsigned_exact_flag", last_flag, 4'b0000);

        cycle(1'b1, 32'hC8_01_10_FF, 32'h02_00_0F_FF, 1'b0, 1'b1, 1'b1, acc);
        idle(3, 1'b1);
        chk("unsigned_sat", last_res, 64'h00FF_0000_00F0_00FF);
        chk("unsigned_sat_flag", last_flag, 4'b1001);

        // Backpressure: 6 back-to-back transactions, output stalled for 4 cycles, modes toggling
        exact_lat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
        idx = 0;
        p0  = pops;
        for (int c = 0; c < 16; c++) begin
            if (idx < 6) begin
                cycle(1'b1, ta[idx], tb[idx], idx[0], idx[1], !(c >= 2 && c < 6), acc);
                if (acc) idx++;
            end else begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            end
        end
        idle(3, 1'b1);
        chk("bp_sent", idx, 6);
        chk("bp_results", pops - p0, 6);
        chk("bp_drained", q.size(), 0);

        // Throughput: 20 back-to-back with the output always ready
        exact_lat = 1'b1;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, acc);
            chk("tp_accept", acc, 1);
        end
        idle(3, 1'b1);
        chk("tp_results", pops - p0, 20);
        chk("tp_drained", q.size(), 0);

        // Random traffic on both handshakes
        exact_lat = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(4, 1'b1);
        chk("rand_drained", q.size(), 0);

        // Reset mid-operation with two transactions in flight
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0, acc);
        chk("mid_acc0", acc, 1);
        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0, acc);
        chk("mid_acc1", acc, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("mid_full_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_flag", sat_flag, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(5, 1'b1);
        chk("post_rst_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
